// File: rtl/rasterizer_pixel_emitter_if.sv
// AXI-Stream style pixel beat channel between the rasterizer and the
// attribute interpolator. One beat carries one covered pixel.
interface rasterizer_pixel_emitter_if;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [63:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/rasterizer_pixel_emitter.sv
// Rasterizer pixel emitter: walks a triangle bounding box row-major, one
// position per clock, evaluates three incremental edge functions and emits
// every covered pixel as a 64-bit stream beat. A one-beat hold register
// delays each covered pixel so the final one can be tagged with tlast.
module rasterizer_pixel_emitter #(
  parameter int X_RESOLUTION = 128,
  parameter int EDGE_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [15:0]           bbox_start_x,
  input  logic [15:0]           bbox_start_y,
  input  logic [15:0]           bbox_end_x,
  input  logic [15:0]           bbox_end_y,
  input  logic [EDGE_WIDTH-1:0] w0,
  input  logic [EDGE_WIDTH-1:0] w1,
  input  logic [EDGE_WIDTH-1:0] w2,
  input  logic [EDGE_WIDTH-1:0] w0_inc_x,
  input  logic [EDGE_WIDTH-1:0] w1_inc_x,
  input  logic [EDGE_WIDTH-1:0] w2_inc_x,
  input  logic [EDGE_WIDTH-1:0] w0_inc_y,
  input  logic [EDGE_WIDTH-1:0] w1_inc_y,
  input  logic [EDGE_WIDTH-1:0] w2_inc_y,
  rasterizer_pixel_emitter_if.master m_axis
);

  localparam logic [31:0] ROW_STRIDE = 32'(X_RESOLUTION);

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, FLUSH = 2'd2} state_t;

  state_t state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [15:0] sx_q, sx_d, ex_q, ex_d, ey_q, ey_d;
  logic [31:0] index_q, index_d, row_index_q, row_index_d;
  logic [2:0][EDGE_WIDTH-1:0] w_q, w_d, row_w_q, row_w_d;
  logic [2:0][EDGE_WIDTH-1:0] inc_x_q, inc_x_d, inc_y_q, inc_y_d;
  logic        hold_valid_q, hold_valid_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [63:0] tdata_q, tdata_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic out_free_s, covered_s, row_end_s, last_pos_s;

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tdata  = tdata_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // Next-state logic: FSM, position/edge stepping, hold register and output beat.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sx_d         = sx_q;
    ex_d         = ex_q;
    ey_d         = ey_q;
    index_d      = index_q;
    row_index_d  = row_index_q;
    w_d          = w_q;
    row_w_d      = row_w_q;
    inc_x_d      = inc_x_q;
    inc_y_d      = inc_y_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    out_free_s = !tvalid_q || m_axis.tready;
    covered_s  = !w_q[0][EDGE_WIDTH-1] && !w_q[1][EDGE_WIDTH-1] && !w_q[2][EDGE_WIDTH-1];
    row_end_s  = (x_q == (ex_q - 16'd1));
    last_pos_s = row_end_s && (y_q == (ey_q - 16'd1));

    // A beat that handshakes this cycle leaves the output unless refilled below.
    if (tvalid_q && m_axis.tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d         = bbox_start_x;
          y_d         = bbox_start_y;
          sx_d        = bbox_start_x;
          ex_d        = bbox_end_x;
          ey_d        = bbox_end_y;
          index_d     = 32'(bbox_start_y) * ROW_STRIDE + 32'(bbox_start_x);
          row_index_d = 32'(bbox_start_y) * ROW_STRIDE + 32'(bbox_start_x);
          w_d         = {w2, w1, w0};
          row_w_d     = {w2, w1, w0};
          inc_x_d     = {w2_inc_x, w1_inc_x, w0_inc_x};
          inc_y_d     = {w2_inc_y, w1_inc_y, w0_inc_y};
          busy_d      = 1'b1;
          if ((bbox_end_x <= bbox_start_x) || (bbox_end_y <= bbox_start_y)) begin
            state_d = FLUSH;
          end else begin
            state_d = WALK;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WALK: begin
        if (out_free_s) begin
          if (covered_s) begin
            if (hold_valid_q) begin
              tvalid_d = 1'b1;
              tlast_d  = 1'b0;
              tdata_d  = hold_data_q;
            end else begin
              tlast_d = tlast_q;
            end
            hold_valid_d = 1'b1;
            hold_data_d  = {index_q, y_q, x_q};
          end else begin
            hold_valid_d = hold_valid_q;
          end
          if (row_end_s) begin
            x_d         = sx_q;
            y_d         = y_q + 16'd1;
            row_index_d = row_index_q + ROW_STRIDE;
            index_d     = row_index_q + ROW_STRIDE;
            for (int i = 0; i < 3; i++) begin
              row_w_d[i] = row_w_q[i] + inc_y_q[i];
              w_d[i]     = row_w_q[i] + inc_y_q[i];
            end
          end else begin
            x_d     = x_q + 16'd1;
            index_d = index_q + 32'd1;
            for (int i = 0; i < 3; i++) begin
              w_d[i] = w_q[i] + inc_x_q[i];
            end
          end
          if (last_pos_s) begin
            state_d = FLUSH;
          end else begin
            state_d = WALK;
          end
        end else begin
          state_d = WALK;
        end
      end
      FLUSH: begin
        if (hold_valid_q) begin
          if (out_free_s) begin
            tvalid_d     = 1'b1;
            tlast_d      = 1'b1;
            tdata_d      = hold_data_q;
            hold_valid_d = 1'b0;
          end else begin
            hold_valid_d = 1'b1;
          end
        end else if (out_free_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        tvalid_d     = 1'b0;
        hold_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that abandons any walk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      sx_q         <= 16'd0;
      ex_q         <= 16'd0;
      ey_q         <= 16'd0;
      index_q      <= 32'd0;
      row_index_q  <= 32'd0;
      w_q          <= '0;
      row_w_q      <= '0;
      inc_x_q      <= '0;
      inc_y_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 64'd0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= 64'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sx_q         <= sx_d;
      ex_q         <= ex_d;
      ey_q         <= ey_d;
      index_q      <= index_d;
      row_index_q  <= row_index_d;
      w_q          <= w_d;
      row_w_q      <= row_w_d;
      inc_x_q      <= inc_x_d;
      inc_y_q      <= inc_y_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_rasterizer_pixel_emitter.sv
// Directed testbench for rasterizer_pixel_emitter: hand-computed beat lists,
// a negedge stream monitor comparing every valid beat against the list.
module tb_rasterizer_pixel_emitter;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done;
  logic [15:0] sx, sy, ex, ey;
  logic [31:0] w0, w1, w2, ix0, ix1, ix2, iy0, iy1, iy2;

  rasterizer_pixel_emitter_if axis ();

  rasterizer_pixel_emitter #(.X_RESOLUTION(128), .EDGE_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .bbox_start_x(sx), .bbox_start_y(sy), .bbox_end_x(ex), .bbox_end_y(ey),
    .w0(w0), .w1(w1), .w2(w2),
    .w0_inc_x(ix0), .w1_inc_x(ix1), .w2_inc_x(ix2),
    .w0_inc_y(iy0), .w1_inc_y(iy1), .w2_inc_y(iy2),
    .m_axis(axis)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {tlast, index, y, x}
  function automatic logic [64:0] bt(input int x, input int y, input int idx, input bit last);
    return {last, 32'(idx), 16'(y), 16'(x)};
  endfunction

  logic [64:0] exp_q[$];
  int rcv, done_cnt, busy_cnt;
  bit mon_en = 1'b0;

  // Stream monitor: every valid beat (stalled or not) must equal the next expected beat.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (axis.tvalid) begin
        if (rcv < exp_q.size()) chk("beat", {axis.tlast, axis.tdata}, exp_q[rcv]);
        else chk("extra_beat", {64'd0, axis.tvalid}, 65'd0);
        if (axis.tready) rcv++;
      end
    end
  end

  task automatic set_tri(input logic [15:0] a_sx, a_sy, a_ex, a_ey,
                         input logic [31:0] a_w0, a_w1, a_w2,
                         input logic [31:0] a_ix0, a_ix1, a_ix2,
                         input logic [31:0] a_iy0, a_iy1, a_iy2);
    sx = a_sx; sy = a_sy; ex = a_ex; ey = a_ey;
    w0 = a_w0; w1 = a_w1; w2 = a_w2;
    ix0 = a_ix0; ix1 = a_ix1; ix2 = a_ix2;
    iy0 = a_iy0; iy1 = a_iy1; iy2 = a_iy2;
  endtask

  // Pulse start, run until done (bounded), then check beat and pulse counts.
  task automatic run(input string tag, input int st_lo, input int st_hi,
                     input int dup_cyc, input int exp_busy);
    rcv = 0; done_cnt = 0; busy_cnt = 0; mon_en = 1'b1;
    axis.tready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 300 && done_cnt == 0; c++) begin
      axis.tready = !(c >= st_lo && c <= st_hi);
      if (c == dup_cyc) begin
        start = 1'b1; ex = 16'd40; w0 = -32'sd7; sx = 16'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    axis.tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, 65'(done_cnt), 65'd1);
    chk({tag, "_beats"}, 65'(rcv), 65'(exp_q.size()));
    if (exp_busy > 0) chk({tag, "_busy_cycles"}, 65'(busy_cnt), 65'(exp_busy));
    chk({tag, "_idle_busy"}, {64'd0, busy}, 65'd0);
    mon_en = 1'b0;
  endtask

  task automatic case1_beats();
    exp_q = {};
    exp_q.push_back(bt(0, 0, 0, 1'b0));
    exp_q.push_back(bt(1, 0, 1, 1'b0));
    exp_q.push_back(bt(2, 0, 2, 1'b0));
    exp_q.push_back(bt(3, 0, 3, 1'b1));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; axis.tready = 1'b1;
    set_tri(16'd0, 16'd0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0,
            32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {64'd0, axis.tvalid}, 65'd0);
    chk("rst_tlast", {64'd0, axis.tlast}, 65'd0);
    chk("rst_tdata", {1'b0, axis.tdata}, 65'd0);
    chk("rst_busy", {64'd0, busy}, 65'd0);
    chk("rst_done", {64'd0, done}, 65'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: full 4x1 box, all inside
    set_tri(16'd0, 16'd0, 16'd4, 16'd1, 32'd0, 32'd0, 32'd0,
            32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    case1_beats();
    run("t1", 0, 0, 0, 0);

    // 2: w0 stepping, one covered pixel per row
    set_tri(16'd2, 16'd3, 16'd4, 16'd5, -32'sd1, 32'd0, 32'd0,
            32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    exp_q = {};
    exp_q.push_back(bt(3, 3, 387, 1'b0));
    exp_q.push_back(bt(3, 4, 515, 1'b1));
    run("t2", 0, 0, 0, 0);

    // 3: empty box
    set_tri(16'd5, 16'd5, 16'd5, 16'd9, 32'd0, 32'd0, 32'd0,
            32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    exp_q = {};
    run("t3", 0, 0, 0, 1);

    // 4: case 1 with backpressure
    set_tri(16'd0, 16'd0, 16'd4, 16'd1, 32'd0, 32'd0, 32'd0,
            32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    case1_beats();
    run("t4", 3, 7, 0, 0);

    // 5: reset after two beats, then a clean rerun
    case1_beats();
    rcv = 0; done_cnt = 0; busy_cnt = 0; mon_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && rcv < 2; c++) begin
      @(posedge clk); #1;
    end
    chk("t5_two_beats_seen", 65'(rcv), 65'd2);
    mon_en = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_tvalid", {64'd0, axis.tvalid}, 65'd0);
    chk("t5_rst_busy", {64'd0, busy}, 65'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_quiet_tvalid", {64'd0, axis.tvalid}, 65'd0);
    case1_beats();
    run("t5_rerun", 0, 0, 0, 0);

    // 6: second start while busy is ignored
    set_tri(16'd0, 16'd0, 16'd4, 16'd1, 32'd0, 32'd0, 32'd0,
            32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    case1_beats();
    run("t6", 0, 0, 2, 0);

    // 7: row crossing near line end, w1 stepping down in x and y
    set_tri(16'd126, 16'd0, 16'd128, 16'd2, 32'd0, 32'd1, 32'd5,
            32'd0, -32'sd1, 32'd0, 32'd0, -32'sd1, 32'd0);
    exp_q = {};
    exp_q.push_back(bt(126, 0, 126, 1'b0));
    exp_q.push_back(bt(127, 0, 127, 1'b0));
    exp_q.push_back(bt(126, 1, 254, 1'b1));
    run("t7", 0, 0, 0, 0);

    // 8: single covered pixel decided by w2
    set_tri(16'd0, 16'd0, 16'd3, 16'd1, 32'd0, 32'd0, -32'sd2,
            32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0);
    exp_q = {};
    exp_q.push_back(bt(2, 0, 2, 1'b1));
    run("t8", 0, 0, 0, 0);

    // 9: nothing covered in a non-empty box
    set_tri(16'd1, 16'd1, 16'd3, 16'd3, 32'd0, -32'sd4, 32'd0,
            32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    exp_q = {};
    run("t9", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
